mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_ctrl_pkg.sv | 14 +
 rtl/hilo_reg.sv | 44 ++++
 rtl/mul_ctrl.sv | 93 +++++++++
 tb/tb_mul_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiply controller and its HI/LO register file.
package mul_ctrl_pkg;

    localparam int unsigned MulLatDefault = 1;
    localparam int unsigned HiLoWidth     = 32;
    localparam int unsigned CntWidth      = 2;   // holds MUL_LAT-1 for MUL_LAT up to 4

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWrite
    } mul_state_e;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO registers; a product write takes priority over MTHI/MTLO.
module hilo_reg
    import mul_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   prod_we_i,
    input  logic [2*HiLoWidth-1:0] prod_i,
    input  logic                   mt_hi_we_i,
    input  logic                   mt_lo_we_i,
    input  logic [HiLoWidth-1:0]   mt_data_i,
    output logic [HiLoWidth-1:0]   hi_o,
    output logic [HiLoWidth-1:0]   lo_o
);

    logic [HiLoWidth-1:0] hi_d, hi_q;
    logic [HiLoWidth-1:0] lo_d, lo_q;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (prod_we_i) begin
            hi_d = prod_i[2*HiLoWidth-1:HiLoWidth];
            lo_d = prod_i[HiLoWidth-1:0];
        end else begin
            if (mt_hi_we_i) hi_d = mt_data_i;
            if (mt_lo_we_i) lo_d = mt_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mul_ctrl.sv
// Sequences one multiply through an external fixed-latency multiplier and
// commits the product into HI/LO; also services MTHI/MTLO while idle.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault
) (
    input  logic                   mul_clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_signed,
    input  logic [HiLoWidth-1:0]   req_x,
    input  logic [HiLoWidth-1:0]   req_y,
    input  logic                   flush,
    output logic                   mul_signed,
    output logic [HiLoWidth-1:0]   mul_x,
    output logic [HiLoWidth-1:0]   mul_y,
    output logic                   mul_resetn,
    input  logic [2*HiLoWidth-1:0] mul_result,
    input  logic                   mt_hi_we,
    input  logic                   mt_lo_we,
    input  logic [HiLoWidth-1:0]   mt_data,
    output logic [HiLoWidth-1:0]   hi,
    output logic [HiLoWidth-1:0]   lo,
    output logic                   busy,
    output logic                   done
);

    mul_state_e           state_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [HiLoWidth-1:0] x_q, y_q;
    logic                 signed_q;

    logic is_idle, prod_we;

    assign is_idle    = (state_q == StIdle);
    assign req_ready  = is_idle & ~flush & ~reset;
    assign busy       = ~is_idle & ~reset;
    // A flush in the write cycle suppresses the commit as well as the pulse.
    assign prod_we    = (state_q == StWrite) & ~flush & ~reset;
    assign done       = prod_we;
    assign mul_resetn = ~reset;
    assign mul_x      = x_q;
    assign mul_y      = y_q;
    assign mul_signed = signed_q;

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        x_q      <= req_x;
                        y_q      <= req_y;
                        signed_q <= req_signed;
                        cnt_q    <= CntWidth'(MUL_LAT - 1);
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        state_q <= StWrite;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StWrite: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    hilo_reg u_hilo_reg (
        .clk_i      (mul_clk),
        .rst_i      (reset),
        .prod_we_i  (prod_we),
        .prod_i     (mul_result),
        .mt_hi_we_i (mt_hi_we & is_idle),
        .mt_lo_we_i (mt_lo_we & is_idle),
        .mt_data_i  (mt_data),
        .hi_o       (hi),
        .lo_o       (lo)
    );

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl at MUL_LAT=1 and MUL_LAT=3, each driving a pipelined multiplier model.
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid3;
    logic        req_signed;
    logic [31:0] req_x, req_y;
    logic        flush;
    logic        mt_hi_we, mt_lo_we;
    logic [31:0] mt_data;

    logic        req_ready, busy, done, mul_signed, mul_resetn;
    logic [31:0] mul_x, mul_y, hi, lo;
    logic [63:0] mul_result;

    logic        req_ready3, busy3, done3, mul_signed3, mul_resetn3;
    logic [31:0] mul_x3, mul_y3, hi3, lo3;
    logic [63:0] mul_result3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.MUL_LAT(1)) dut (
        .mul_clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_x(req_x), .req_y(req_y), .flush(flush),
        .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y), .mul_resetn(mul_resetn),
        .mul_result(mul_result), .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we),
        .mt_data(mt_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    mul_ctrl #(.MUL_LAT(3)) dut3 (
        .mul_clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_signed(req_signed), .req_x(req_x), .req_y(req_y), .flush(flush),
        .mul_signed(mul_signed3), .mul_x(mul_x3), .mul_y(mul_y3), .mul_resetn(mul_resetn3),
        .mul_result(mul_result3), .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we),
        .mt_data(mt_data), .hi(hi3), .lo(lo3), .busy(busy3), .done(done3)
    );

    function automatic logic [63:0] mult(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Multiplier models: MUL_LAT register stages from operands to product.
    logic [63:0] pipe1_q;
    logic [63:0] pipe3_q [3];
    always_ff @(posedge clk) begin
        pipe1_q    <= mult(mul_signed, mul_x, mul_y);
        pipe3_q[0] <= mult(mul_signed3, mul_x3, mul_y3);
        pipe3_q[1] <= pipe3_q[0];
        pipe3_q[2] <= pipe3_q[1];
    end
    assign mul_result  = pipe1_q;
    assign mul_result3 = pipe3_q[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle's drive point; checks follow after #1.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic s, input logic [31:0] x, input logic [31:0] y);
        req_valid  = 1'b1;
        req_signed = s;
        req_x      = x;
        req_y      = y;
    endtask

    initial begin
        reset = 1'b1; req_valid = 0; req_valid3 = 0; req_signed = 0; req_x = 0; req_y = 0;
        flush = 0; mt_hi_we = 0; mt_lo_we = 0; mt_data = 0;

        // Reset state and outputs
        cyc(); #1;
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resetn", mul_resetn, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_mulx", mul_x, 0);
        check("rst_ready3", req_ready3, 0);

        cyc(); reset = 0; #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_resetn", mul_resetn, 1);

        // Unsigned all-ones squared
        drive_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        check("u_accept_ready", req_ready, 1);
        cyc(); req_valid = 0; #1;
        check("u_busy", busy, 1);
        check("u_ready_busy", req_ready, 0);
        check("u_done_wait", done, 0);
        check("u_mulx", mul_x, 32'hFFFF_FFFF);
        check("u_muls", mul_signed, 0);
        cyc(); #1;
        check("u_done", done, 1);
        cyc(); #1;
        check("u_hi", hi, 32'hFFFF_FFFE);
        check("u_lo", lo, 32'h0000_0001);
        check("u_ready_again", req_ready, 1);
        check("u_done_off", done, 0);

        // Signed min*min, then signed -1*-1 back-to-back
        drive_req(1, 32'h8000_0000, 32'h8000_0000); #1;
        cyc(); req_valid = 0; #1;
        check("s1_muls", mul_signed, 1);
        cyc(); #1;
        check("s1_done", done, 1);
        cyc(); drive_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        check("s1_hi", hi, 32'h4000_0000);
        check("s1_lo", lo, 32'h0);
        check("b2b_ready", req_ready, 1);
        cyc(); req_valid = 0; #1;
        check("b2b_busy", busy, 1);
        cyc(); #1;
        check("s2_done", done, 1);
        cyc(); #1;
        check("s2_hi", hi, 32'h0);
        check("s2_lo", lo, 32'h1);

        // MT preload, then flush during WAIT
        mt_hi_we = 1; mt_data = 32'h1234_5678;
        cyc(); mt_hi_we = 0; mt_lo_we = 1; mt_data = 32'h9ABC_DEF0;
        cyc(); mt_lo_we = 0; drive_req(0, 32'd3, 32'd5);
        cyc(); req_valid = 0; flush = 1; #1;
        check("fl_done", done, 0);
        check("fl_busy", busy, 1);
        cyc(); flush = 0; #1;
        check("fl_idle", busy, 0);
        check("fl_ready", req_ready, 1);
        check("fl_done_after", done, 0);
        check("fl_hi", hi, 32'h1234_5678);
        check("fl_lo", lo, 32'h9ABC_DEF0);

        // Flush in IDLE blocks acceptance
        drive_req(0, 32'd9, 32'd9); flush = 1; #1;
        check("fl_idle_ready", req_ready, 0);
        cyc(); req_valid = 0; flush = 0; #1;
        check("fl_idle_noaccept", busy, 0);

        // MTHI in IDLE, MTLO ignored while busy
        mt_hi_we = 1; mt_data = 32'hAAAA_0000;
        cyc(); mt_hi_we = 0; drive_req(0, 32'd2, 32'd3);
        cyc(); req_valid = 0; mt_lo_we = 1; mt_data = 32'h5555_5555; #1;
        check("mt_busy1", busy, 1);
        check("mt_hi", hi, 32'hAAAA_0000);
        cyc(); mt_lo_we = 0; #1;
        check("mt_busy2", busy, 1);
        check("mt_lo_ignored", lo, 32'h9ABC_DEF0);
        check("mt_done", done, 1);
        cyc(); #1;
        check("mt_busy_end", busy, 0);
        check("mt_prod_hi", hi, 32'h0);
        check("mt_prod_lo", lo, 32'h6);

        // MTLO in the same cycle as an accepted request
        drive_req(0, 32'd7, 32'd6); mt_lo_we = 1; mt_data = 32'hDEAD_BEEF;
        cyc(); req_valid = 0; mt_lo_we = 0; #1;
        check("same_mt_lo", lo, 32'hDEAD_BEEF);
        cyc();
        cyc(); #1;
        check("same_prod_lo", lo, 32'h2A);

        // Holding req_valid while busy leaves operands alone
        drive_req(0, 32'h10, 32'h20);
        cyc(); req_x = 32'h99; req_y = 32'h77; #1;
        check("hold_mulx_wait", mul_x, 32'h10);
        cyc(); req_valid = 0; #1;
        check("hold_muly_write", mul_y, 32'h20);
        cyc(); #1;
        check("hold_lo", lo, 32'h200);

        // Reset during WAIT
        drive_req(0, 32'd5, 32'd5);
        cyc(); req_valid = 0; reset = 1; #1;
        check("rw_ready", req_ready, 0);
        check("rw_busy", busy, 0);
        check("rw_done", done, 0);
        cyc(); reset = 0; #1;
        check("rw_hi", hi, 32'h0);
        check("rw_lo", lo, 32'h0);
        check("rw_done2", done, 0);
        check("rw_ready2", req_ready, 1);
        cyc(); #1;
        check("rw_done3", done, 0);

        // MUL_LAT=3: done at T+4
        req_valid3 = 1; req_signed = 0; req_x = 32'h8000_0000; req_y = 32'd2; #1;
        check("l3_ready", req_ready3, 1);
        cyc(); req_valid3 = 0; #1;
        check("l3_busy", busy3, 1);
        check("l3_done_t1", done3, 0);
        cyc(); #1;
        check("l3_done_t2", done3, 0);
        cyc(); #1;
        check("l3_done_t3", done3, 0);
        cyc(); #1;
        check("l3_done_t4", done3, 1);
        cyc(); #1;
        check("l3_hi", hi3, 32'h1);
        check("l3_lo", lo3, 32'h0);
        check("l3_ready_again", req_ready3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
